legv8_mc_ctrl: RTL and testbench
================================

Name: legv8_mc_ctrl

Overview:
- Multicycle control sequencer for the ARMv8/LEGv8 datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the sign-extend unit's 2-bit select, ALU, register-file and memory controls, and stalls on a memory ready handshake.
- Sits between the instruction register (opcode field) and the shared datapath: one register file, one ALU, one SEU, one unified memory.

Parameters:
- OPW, 11, opcode width (instruction bits [31:21]).
- MEM_TIMEOUT, 15, max cycles waiting on mem_ready before trap; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  11  IR[31:21], valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in EXEC
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  load PC
- pc_src  out  2  00 PC+4, 01 PC+branch offset, 10 hold
- ir_write  out  1  load IR
- sseu  out  2  SEU select: 00 [21:10] zero-ext (I-type), 01 [25:0] (B), 10 [23:5] (CB), 11 [20:12] (D-type)
- reg2loc  out  1  read reg2 from Rt[4:0] (CBZ/STUR)
- alu_src  out  1  ALU operand B = SEU output
- alu_op  out  2  00 add, 01 pass-B/zero-test, 10 R-type funct
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  0 address=PC, 1 address=ALU result
- reg_write  out  1  write register file
- mem_to_reg  out  1  writeback from memory data
- state  out  3  current state encoding, for debug
- trap  out  1  sticky illegal-opcode/timeout flag

Behaviour:
- Reset (async, rst_n=0): state=FETCH; all outputs 0 except pc_src=10; trap=0; wait counter=0. Asserting reset mid-access drops mem_read/mem_write immediately.
- Encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Outputs are a Moore function of state plus latched decode class.
- FETCH:
  - mem_read=1, i_or_d=0 held until mem_ready.
  - On the mem_ready cycle, ir_write=1, pc_write=1, pc_src=00; next state DECODE.
- DECODE:
  - Classify opcode, latch class.
  - R: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - I: ADDI/SUBI 1001000100x/1101000100x.
  - LD 11111000010; ST 11111000000; CB: CBZ 10110100xxx; B: 000101xxxxx.
  - Anything else goes to TRAP; otherwise next state EXEC.
- EXEC:
  - sseu per class (I=00, B=01, CB=10, LD/ST=11; R=don't care, driven 00).
  - R: alu_op=10, alu_src=0, then WB.
  - I: alu_op=10, alu_src=1, then WB.
  - LD/ST: alu_op=00, alu_src=1, then MEM.
  - CB: reg2loc=1, alu_op=01. If zero=1, pc_write=1 and pc_src=01. Next state FETCH.
  - B: pc_write=1, pc_src=01; next state FETCH.
- MEM:
  - i_or_d=1; LD asserts mem_read, ST asserts mem_write (with reg2loc=1); request held until mem_ready.
  - On mem_ready: LD goes to WB, ST goes to FETCH.
- WB: reg_write=1 for one cycle; mem_to_reg=1 for LD only; next state FETCH.
- Memory wait counter:
  - Increments each FETCH/MEM cycle with mem_ready=0; clears on state change.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT, go to TRAP.
  - mem_ready in the same cycle as the timeout wins (access completes).
- TRAP: trap=1, all strobes 0, pc_src=10; stays until reset.
- Timing: mem_ready has zero-cycle latency; the earliest possible completion is in the first request cycle.
- Cycle counts with zero-wait memory: R/I=4, LD=5, ST=4, CB/B=3.
- mem_ready while no request is outstanding is ignored.

Decomposition:
- Shared package legv8_pkg:
  - state encodings
  - sseu select constants (SEU_I=00, SEU_B=01, SEU_CB=10, SEU_D=11)
  - alu_op constants
  - opcode patterns/masks
  - instruction-class enum
- One sub-module: legv8_opdecode, a combinational opcode→class+illegal decoder, reused by the bench scoreboard.

Test Plan:
- Reset mid-FETCH with mem_read=1, rst_n pulsed low → outputs clear asynchronously, state=0; after release, FETCH restarts with mem_read=1.
- ADDI (opcode 10010001000), mem_ready always 1 → states 0,1,2,4,0; EXEC shows sseu=00, alu_src=1; reg_write=1 exactly one cycle.
- LDUR (11111000010), 3 wait cycles in MEM → mem_read=1 and i_or_d=1 for 4 cycles, sseu=11 in EXEC, WB with mem_to_reg=1; total 8 cycles.
- CBZ (10110100101) with zero=1 → sseu=10, pc_write=1 and pc_src=01 in EXEC. Repeat with zero=0 → pc_write=0 in EXEC; back to FETCH either way.
- B (00010100000) → sseu=01, pc_src=01, 3-cycle instruction.
- Opcode 00000000000 → TRAP, trap=1 sticky across 20 cycles. Separately, mem_ready held 0 for 15 FETCH cycles (MEM_TIMEOUT=15) → TRAP.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 multicycle control sequencer.
package legv8_pkg;

    localparam int unsigned OP_W = 11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_R  = 3'd0,
        CLS_I  = 3'd1,
        CLS_LD = 3'd2,
        CLS_ST = 3'd3,
        CLS_CB = 3'd4,
        CLS_B  = 3'd5
    } instr_class_e;

    localparam logic [1:0] SEU_I  = 2'b00;
    localparam logic [1:0] SEU_B  = 2'b01;
    localparam logic [1:0] SEU_CB = 2'b10;
    localparam logic [1:0] SEU_D  = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
    localparam logic [1:0] PC_SRC_BR   = 2'b01;
    localparam logic [1:0] PC_SRC_HOLD = 2'b10;

    localparam logic [OP_W-1:0] MASK_FULL = 11'b11111111111;
    localparam logic [OP_W-1:0] MASK_I    = 11'b11111111110;
    localparam logic [OP_W-1:0] MASK_CB   = 11'b11111111000;
    localparam logic [OP_W-1:0] MASK_B    = 11'b11111100000;

    localparam logic [OP_W-1:0] OP_ADD  = 11'b10001011000;
    localparam logic [OP_W-1:0] OP_SUB  = 11'b11001011000;
    localparam logic [OP_W-1:0] OP_AND  = 11'b10001010000;
    localparam logic [OP_W-1:0] OP_ORR  = 11'b10101010000;
    localparam logic [OP_W-1:0] OP_ADDI = 11'b10010001000;
    localparam logic [OP_W-1:0] OP_SUBI = 11'b11010001000;
    localparam logic [OP_W-1:0] OP_LDUR = 11'b11111000010;
    localparam logic [OP_W-1:0] OP_STUR = 11'b11111000000;
    localparam logic [OP_W-1:0] OP_CBZ  = 11'b10110100000;
    localparam logic [OP_W-1:0] OP_B    = 11'b00010100000;

    // Control strobes driven onto the shared datapath.
    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic [1:0] sseu;
        logic       reg2loc;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       mem_to_reg;
        logic       trap;
    } ctrl_t;

    function automatic logic op_match(input logic [OP_W-1:0] op,
                                      input logic [OP_W-1:0] pat,
                                      input logic [OP_W-1:0] mask);
        return (op & mask) == (pat & mask);
    endfunction

endpackage

// File: rtl/legv8_opdecode.sv
// Combinational opcode classifier: instruction class plus illegal flag.
module legv8_opdecode
    import legv8_pkg::*;
(
    input  logic [OP_W-1:0] opcode_i,
    output instr_class_e    class_o,
    output logic            illegal_o
);

    always_comb begin
        class_o   = CLS_R;
        illegal_o = 1'b0;
        if (op_match(opcode_i, OP_ADD, MASK_FULL) || op_match(opcode_i, OP_SUB, MASK_FULL) ||
            op_match(opcode_i, OP_AND, MASK_FULL) || op_match(opcode_i, OP_ORR, MASK_FULL)) begin
            class_o = CLS_R;
        end else if (op_match(opcode_i, OP_ADDI, MASK_I) || op_match(opcode_i, OP_SUBI, MASK_I)) begin
            class_o = CLS_I;
        end else if (op_match(opcode_i, OP_LDUR, MASK_FULL)) begin
            class_o = CLS_LD;
        end else if (op_match(opcode_i, OP_STUR, MASK_FULL)) begin
            class_o = CLS_ST;
        end else if (op_match(opcode_i, OP_CBZ, MASK_CB)) begin
            class_o = CLS_CB;
        end else if (op_match(opcode_i, OP_B, MASK_B)) begin
            class_o = CLS_B;
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/legv8_mc_ctrl.sv
// LEGv8 multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// ready handshake, wait timeout and sticky trap.
module legv8_mc_ctrl
    import legv8_pkg::*;
#(
    parameter int unsigned OPW         = 11,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic [1:0]     pc_src,
    output logic           ir_write,
    output logic [1:0]     sseu,
    output logic           reg2loc,
    output logic           alu_src,
    output logic [1:0]     alu_op,
    output logic           mem_read,
    output logic           mem_write,
    output logic           i_or_d,
    output logic           reg_write,
    output logic           mem_to_reg,
    output logic [2:0]     state,
    output logic           trap
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W + 1)'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    instr_class_e      class_q, class_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [CNT_W:0]    wait_inc;
    logic              timeout;
    instr_class_e      dec_class;
    logic              dec_illegal;
    ctrl_t             ctrl;

    legv8_opdecode u_opdecode (
        .opcode_i  (OP_W'(opcode)),
        .class_o   (dec_class),
        .illegal_o (dec_illegal)
    );

    assign wait_inc = {1'b0, wait_q} + (CNT_W + 1)'(1);
    assign timeout  = (MEM_TIMEOUT != 0) && (wait_inc == TIMEOUT_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            class_q <= CLS_R;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
        end
    end

    // Next state and Moore strobes (plus handshake / zero qualified strobes).
    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        wait_d      = wait_q;
        ctrl        = '0;
        ctrl.pc_src = PC_SRC_HOLD;

        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_SRC_SEQ;
                    state_d       = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                state_d = dec_illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (class_q)
                    CLS_R: begin
                        ctrl.alu_op = ALU_FUNCT;
                        state_d     = ST_WB;
                    end
                    CLS_I: begin
                        ctrl.sseu    = SEU_I;
                        ctrl.alu_op  = ALU_FUNCT;
                        ctrl.alu_src = 1'b1;
                        state_d      = ST_WB;
                    end
                    CLS_LD, CLS_ST: begin
                        ctrl.sseu    = SEU_D;
                        ctrl.alu_op  = ALU_ADD;
                        ctrl.alu_src = 1'b1;
                        state_d      = ST_MEM;
                    end
                    CLS_CB: begin
                        ctrl.sseu    = SEU_CB;
                        ctrl.reg2loc = 1'b1;
                        ctrl.alu_op  = ALU_PASSB;
                        if (zero) begin
                            ctrl.pc_write = 1'b1;
                            ctrl.pc_src   = PC_SRC_BR;
                        end
                    end
                    CLS_B: begin
                        ctrl.sseu     = SEU_B;
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_SRC_BR;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                ctrl.i_or_d = 1'b1;
                if (class_q == CLS_ST) begin
                    ctrl.mem_write = 1'b1;
                    ctrl.reg2loc   = 1'b1;
                end else begin
                    ctrl.mem_read = 1'b1;
                end
                if (mem_ready) begin
                    state_d = (class_q == CLS_ST) ? ST_FETCH : ST_WB;
                end else if (timeout) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = (class_q == CLS_LD);
                state_d         = ST_FETCH;
            end
            ST_TRAP: begin
                ctrl.trap = 1'b1;
            end
            default: state_d = ST_TRAP;
        endcase

        // Wait counter runs only while an access is pending in the same state.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if ((state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready) begin
            wait_d = wait_inc[CNT_W-1:0];
        end

        // Strobes must drop immediately when reset is asserted mid-access.
        if (!rst_n) begin
            ctrl        = '0;
            ctrl.pc_src = PC_SRC_HOLD;
        end
    end

    assign pc_write   = ctrl.pc_write;
    assign pc_src     = ctrl.pc_src;
    assign ir_write   = ctrl.ir_write;
    assign sseu       = ctrl.sseu;
    assign reg2loc    = ctrl.reg2loc;
    assign alu_src    = ctrl.alu_src;
    assign alu_op     = ctrl.alu_op;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign i_or_d     = ctrl.i_or_d;
    assign reg_write  = ctrl.reg_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign trap       = ctrl.trap;
    assign state      = state_q;

endmodule

// File: tb/tb_legv8_mc_ctrl.sv
// Directed bench for legv8_mc_ctrl: per-instruction vector table plus
// hand-written reset, timeout and trap sequences.
module tb_legv8_mc_ctrl;
    import legv8_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, reg2loc, alu_src;
    logic        mem_read, mem_write, i_or_d, reg_write, mem_to_reg, trap;
    logic [1:0]  pc_src, sseu, alu_op;
    logic [2:0]  state;

    instr_class_e ref_class;
    logic         ref_ill;

    int errors = 0;
    int checks = 0;

    legv8_mc_ctrl #(.OPW(11), .MEM_TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .sseu       (sseu),
        .reg2loc    (reg2loc),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .state      (state),
        .trap       (trap)
    );

    legv8_opdecode u_ref (
        .opcode_i  (opcode),
        .class_o   (ref_class),
        .illegal_o (ref_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0]  op;
        logic         zero;
        int           mwait;
        logic         trp;
        instr_class_e cls;
        int           cycles;
        logic [1:0]   sseu;
        logic         alu_src;
        logic [1:0]   alu_op;
        logic         pcw;
        logic [1:0]   pcs;
        logic         r2l;
        int           wbcnt;
        logic         m2r;
        int           memcnt;
        logic         is_st;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic logic [18:0] outs();
        return {pc_write, pc_src, ir_write, sseu, reg2loc, alu_src, alu_op,
                mem_read, mem_write, i_or_d, reg_write, mem_to_reg, state, trap};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic sticky_check(input string name);
        int bad;
        bad = 0;
        mem_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!(trap && state == 3'd7 && !mem_read && !mem_write && !pc_write &&
                  !ir_write && !reg_write && pc_src == 2'b10)) bad++;
        end
        check(name, bad, 0);
    endtask

    logic [18:0] idle_exp;
    int          waits, ncyc, wbcnt, memcnt;
    logic        fetch_ok, c_m2r, c_alu_src, c_pcw, c_r2l;
    logic [1:0]  c_sseu, c_alu_op, c_pcs;
    bit          mem_ok;

    initial begin
        idle_exp = {1'b0, 2'b10, 16'h0000};
        //            op             z     w  trp  cls     cyc sseu   src   aluop  pcw   pcs    r2l  wb m2r  mem st
        vecs[0]  = '{11'b10001011000, 1'b0, 0, 1'b0, CLS_R,  4, 2'b00, 1'b0, 2'b10, 1'b0, 2'b10, 1'b0, 1, 1'b0, 0, 1'b0};
        vecs[1]  = '{11'b11001011000, 1'b0, 0, 1'b0, CLS_R,  4, 2'b00, 1'b0, 2'b10, 1'b0, 2'b10, 1'b0, 1, 1'b0, 0, 1'b0};
        vecs[2]  = '{11'b10001010000, 1'b1, 0, 1'b0, CLS_R,  4, 2'b00, 1'b0, 2'b10, 1'b0, 2'b10, 1'b0, 1, 1'b0, 0, 1'b0};
        vecs[3]  = '{11'b10101010000, 1'b0, 0, 1'b0, CLS_R,  4, 2'b00, 1'b0, 2'b10, 1'b0, 2'b10, 1'b0, 1, 1'b0, 0, 1'b0};
        vecs[4]  = '{11'b10010001000, 1'b0, 0, 1'b0, CLS_I,  4, 2'b00, 1'b1, 2'b10, 1'b0, 2'b10, 1'b0, 1, 1'b0, 0, 1'b0};
        vecs[5]  = '{11'b11010001001, 1'b0, 0, 1'b0, CLS_I,  4, 2'b00, 1'b1, 2'b10, 1'b0, 2'b10, 1'b0, 1, 1'b0, 0, 1'b0};
        vecs[6]  = '{11'b11111000010, 1'b0, 0, 1'b0, CLS_LD, 5, 2'b11, 1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 1, 1'b1, 1, 1'b0};
        vecs[7]  = '{11'b11111000010, 1'b0, 3, 1'b0, CLS_LD, 8, 2'b11, 1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 1, 1'b1, 4, 1'b0};
        vecs[8]  = '{11'b11111000000, 1'b0, 0, 1'b0, CLS_ST, 4, 2'b11, 1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 0, 1'b0, 1, 1'b1};
        vecs[9]  = '{11'b11111000000, 1'b0, 2, 1'b0, CLS_ST, 6, 2'b11, 1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 0, 1'b0, 3, 1'b1};
        vecs[10] = '{11'b10110100101, 1'b1, 0, 1'b0, CLS_CB, 3, 2'b10, 1'b0, 2'b01, 1'b1, 2'b01, 1'b1, 0, 1'b0, 0, 1'b0};
        vecs[11] = '{11'b10110100101, 1'b0, 0, 1'b0, CLS_CB, 3, 2'b10, 1'b0, 2'b01, 1'b0, 2'b10, 1'b1, 0, 1'b0, 0, 1'b0};
        vecs[12] = '{11'b00010100000, 1'b0, 0, 1'b0, CLS_B,  3, 2'b01, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 0, 1'b0, 0, 1'b0};
        vecs[13] = '{11'b00010111111, 1'b1, 0, 1'b0, CLS_B,  3, 2'b01, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 0, 1'b0, 0, 1'b0};
        vecs[14] = '{11'b00000000000, 1'b0, 0, 1'b1, CLS_R,  2, 2'b00, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 0, 1'b0, 0, 1'b0};
        vecs[15] = '{11'b10001011001, 1'b0, 0, 1'b1, CLS_R,  2, 2'b00, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 0, 1'b0, 0, 1'b0};

        rst_n     = 1'b0;
        opcode    = 11'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Held in reset with mem_ready high: everything idle.
        #12;
        check("reset_outputs", int'(outs()), int'(idle_exp));

        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("fetch_after_release", int'({mem_read, i_or_d, state}), int'({1'b1, 1'b0, 3'd0}));

        // Asynchronous reset in the middle of a pending fetch.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midfetch_reset_outputs", int'(outs()), int'(idle_exp));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("fetch_restart", int'({mem_read, i_or_d, state}), int'({1'b1, 1'b0, 3'd0}));
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            opcode    = vecs[i].op;
            zero      = vecs[i].zero;
            waits     = vecs[i].mwait;
            ncyc      = 0;
            wbcnt     = 0;
            memcnt    = 0;
            fetch_ok  = 1'b0;
            c_m2r     = 1'b0;
            c_sseu    = 2'b00;
            c_alu_src = 1'b0;
            c_alu_op  = 2'b00;
            c_pcw     = 1'b0;
            c_pcs     = 2'b10;
            c_r2l     = 1'b0;
            for (int c = 0; c < 30; c++) begin
                mem_ready = !(state == 3'd3 && waits > 0);
                @(negedge clk);
                if (c == 0) fetch_ok = mem_read && !i_or_d && ir_write && pc_write && pc_src == 2'b00;
                if (state == 3'd2) begin
                    c_sseu = sseu; c_alu_src = alu_src; c_alu_op = alu_op;
                    c_pcw = pc_write; c_pcs = pc_src; c_r2l = reg2loc;
                end
                if (state == 3'd3) begin
                    mem_ok = vecs[i].is_st ? (mem_write && !mem_read && reg2loc) : (mem_read && !mem_write);
                    if (mem_ok && i_or_d) memcnt++;
                    if (!mem_ready) waits--;
                end
                if (state == 3'd4) begin
                    if (reg_write) wbcnt++;
                    if (mem_to_reg) c_m2r = 1'b1;
                end
                ncyc++;
                @(posedge clk);
                #1;
                if (state == 3'd0 || state == 3'd7) break;
            end
            check($sformatf("v%0d_cycles", i), ncyc, vecs[i].cycles);
            check($sformatf("v%0d_end_state", i), int'(state), vecs[i].trp ? 7 : 0);
            check($sformatf("v%0d_ref_illegal", i), int'(ref_ill), int'(vecs[i].trp));
            if (vecs[i].trp) begin
                check($sformatf("v%0d_trap", i), int'(trap), 1);
                do_reset();
            end else begin
                check($sformatf("v%0d_ref_class", i), int'(ref_class), int'(vecs[i].cls));
                check($sformatf("v%0d_fetch", i), int'(fetch_ok), 1);
                check($sformatf("v%0d_sseu", i), int'(c_sseu), int'(vecs[i].sseu));
                check($sformatf("v%0d_alu_src", i), int'(c_alu_src), int'(vecs[i].alu_src));
                check($sformatf("v%0d_alu_op", i), int'(c_alu_op), int'(vecs[i].alu_op));
                check($sformatf("v%0d_pc_write", i), int'(c_pcw), int'(vecs[i].pcw));
                check($sformatf("v%0d_pc_src", i), int'(c_pcs), int'(vecs[i].pcs));
                check($sformatf("v%0d_reg2loc", i), int'(c_r2l), int'(vecs[i].r2l));
                check($sformatf("v%0d_reg_write", i), wbcnt, vecs[i].wbcnt);
                check($sformatf("v%0d_mem_to_reg", i), int'(c_m2r), int'(vecs[i].m2r));
                check($sformatf("v%0d_mem_cycles", i), memcnt, vecs[i].memcnt);
            end
        end

        // Illegal opcode trap is sticky.
        do_reset();
        opcode    = 11'b00000000000;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("illegal_trap_state", int'(state), 7);
        sticky_check("illegal_trap_sticky");

        // Fetch wait: 14 idle cycles survive, ready on the 15th wins.
        do_reset();
        opcode    = 11'b10001011000;
        mem_ready = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("fetch_wait14_state", int'(state), 0);
        mem_ready = 1'b1;
        @(negedge clk);
        check("fetch_ready_at_limit", int'(ir_write), 1);
        @(posedge clk);
        #1;
        check("fetch_ready_decode", int'(state), 1);
        repeat (3) @(posedge clk);
        #1;
        check("add_done_fetch", int'(state), 0);

        // Fetch timeout: 15 cycles without ready traps.
        mem_ready = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("fetch_wait14_again", int'(state), 0);
        @(posedge clk);
        #1;
        check("fetch_timeout_trap", int'({state, trap}), int'({3'd7, 1'b1}));
        sticky_check("timeout_trap_sticky");

        // MEM timeout on a load.
        do_reset();
        opcode    = 11'b11111000010;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ld_in_mem", int'(state), 3);
        mem_ready = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("mem_wait14_state", int'({state, mem_read, i_or_d}), int'({3'd3, 1'b1, 1'b1}));
        @(posedge clk);
        #1;
        check("mem_timeout_trap", int'({state, trap}), int'({3'd7, 1'b1}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
